// File: rtl/ram2e_efb_responder_pkg.sv
// Shared constants for the RAM2E EFB responder: register map,
// UFM opcodes and the command-frame FSM states.
package ram2e_efb_responder_pkg;

    localparam logic [7:0] ADR_CFGCR   = 8'h70;
    localparam logic [7:0] ADR_CFGTXDR = 8'h71;
    localparam logic [7:0] ADR_CFGRXDR = 8'h73;

    localparam logic [7:0] OP_ENABLE  = 8'h74;
    localparam logic [7:0] OP_STATUS  = 8'h3C;
    localparam logic [7:0] OP_SETPAGE = 8'hB4;
    localparam logic [7:0] OP_READ    = 8'hCA;
    localparam logic [7:0] OP_PROG    = 8'hC9;
    localparam logic [7:0] OP_ERASE   = 8'hCB;
    localparam logic [7:0] OP_DISABLE = 8'h26;
    localparam logic [7:0] OP_REFRESH = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_OPND,
        ST_DIN,
        ST_DOUT
    } efb_state_e;

    // Data-phase length of a command: full page for read/program,
    // one 4-byte word for status and set-page.
    function automatic logic [4:0] xfer_len(input logic [7:0] opc);
        return (opc == OP_PROG || opc == OP_READ) ? 5'd16 : 5'd4;
    endfunction

endpackage

// File: rtl/ram2e_efb_wb_ack.sv
// Wishbone acknowledge generator: one registered ack per strobe.
// Ports: clk_i/rst_i, cyc_i/stb_i in; ack_o (registered), fire_o
// (single-cycle qualifier, high on the edge that raises ack_o).
module ram2e_efb_wb_ack (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cyc_i,
    input  logic stb_i,
    output logic ack_o,
    output logic fire_o
);

    logic req;
    logic ack_q;
    logic done_q;

    assign req = cyc_i & stb_i;

    // done_q remembers that the current strobe was already served,
    // so a strobe held for several cycles gets exactly one ack.
    assign fire_o = req & ~ack_q & ~done_q;
    assign ack_o  = ack_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ack_q  <= fire_o;
            done_q <= req & (done_q | fire_o);
        end
    end

endmodule

// File: rtl/ram2e_efb_responder.sv
// RAM2E EFB responder: emulates the UFM command interface behind a
// Wishbone slave. Ports: wb_* Wishbone slave, wbc_ufm_irq program-done
// pulse, cfg_en configuration-enabled flag.
module ram2e_efb_responder
    import ram2e_efb_responder_pkg::*;
#(
    parameter int         PAGES   = 4,
    parameter logic [7:0] INIT_B0 = 8'h00,
    parameter logic [7:0] INIT_B1 = 8'h01
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       wbc_ufm_irq,
    output logic       cfg_en
);

    localparam int PW = $clog2(PAGES);
    localparam int NB = PAGES * 16;

    logic          fire;
    efb_state_e    state_q;
    logic [7:0]    opc_q;
    logic [4:0]    cnt_q;
    logic [PW-1:0] page_q;
    logic          cfg_en_q;
    logic          irq_q;
    logic [7:0]    dat_q;
    logic [7:0]    mem_q [NB];
    logic [7:0]    buf_q [16];

    logic       wr_cr;
    logic       wr_tx;
    logic       rd_rx;
    logic [4:0] len;
    logic       last_xfer;
    logic [7:0] rd_byte;

    ram2e_efb_wb_ack u_ack (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .cyc_i  (wb_cyc_i),
        .stb_i  (wb_stb_i),
        .ack_o  (wb_ack_o),
        .fire_o (fire)
    );

    assign wr_cr = fire & wb_we_i & (wb_adr_i == ADR_CFGCR);
    assign wr_tx = fire & wb_we_i & (wb_adr_i == ADR_CFGTXDR);
    assign rd_rx = fire & ~wb_we_i & (wb_adr_i == ADR_CFGRXDR);

    assign len       = xfer_len(opc_q);
    assign last_xfer = (cnt_q == len - 5'd1);

    assign wb_dat_o    = dat_q;
    assign wbc_ufm_irq = irq_q;
    assign cfg_en      = cfg_en_q;

    // In DOUT the opcode is either a page read or a status read.
    always_comb begin
        rd_byte = 8'h00;
        if (state_q == ST_DOUT && cnt_q < len) begin
            if (opc_q == OP_READ)
                rd_byte = mem_q[{page_q, cnt_q[3:0]}];
            else if (cnt_q == 5'd3)
                rd_byte = {7'b0, cfg_en_q};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            opc_q    <= 8'h00;
            cnt_q    <= 5'd0;
            page_q   <= '0;
            cfg_en_q <= 1'b0;
            irq_q    <= 1'b0;
            dat_q    <= 8'h00;
            for (int i = 0; i < NB; i++)
                mem_q[i] <= (i == 0) ? INIT_B0 :
                            (i == 1) ? INIT_B1 : 8'h00;
            for (int i = 0; i < 16; i++)
                buf_q[i] <= 8'h00;
        end else begin
            irq_q <= 1'b0;
            dat_q <= 8'h00;

            if (rd_rx) begin
                dat_q <= rd_byte;
                if (state_q == ST_DOUT && cnt_q < len) begin
                    cnt_q <= cnt_q + 5'd1;
                    if (opc_q == OP_READ && cnt_q == 5'd15)
                        page_q <= page_q + 1'b1;
                end
            end

            if (wr_cr) begin
                state_q <= wb_dat_i[7] ? ST_OPC : ST_IDLE;
                cnt_q   <= 5'd0;
            end else if (wr_tx) begin
                case (state_q)
                    ST_OPC: begin
                        opc_q <= wb_dat_i;
                        if (wb_dat_i == OP_REFRESH) begin
                            cfg_en_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q <= ST_OPND;
                            cnt_q   <= (wb_dat_i == OP_DISABLE) ? 5'd2 : 5'd3;
                        end
                    end
                    ST_OPND: begin
                        if (cnt_q != 5'd1) begin
                            cnt_q <= cnt_q - 5'd1;
                        end else begin
                            cnt_q   <= 5'd0;
                            state_q <= ST_IDLE;
                            case (opc_q)
                                OP_ENABLE:  cfg_en_q <= 1'b1;
                                OP_DISABLE: cfg_en_q <= 1'b0;
                                OP_STATUS:  state_q  <= ST_DOUT;
                                OP_READ:
                                    if (cfg_en_q) state_q <= ST_DOUT;
                                OP_SETPAGE, OP_PROG:
                                    if (cfg_en_q) state_q <= ST_DIN;
                                OP_ERASE:
                                    if (cfg_en_q)
                                        for (int i = 0; i < NB; i++)
                                            mem_q[i] <= 8'h00;
                                default: ;
                            endcase
                        end
                    end
                    ST_DIN: begin
                        cnt_q <= cnt_q + 5'd1;
                        if (opc_q == OP_SETPAGE) begin
                            if (last_xfer) begin
                                page_q  <= wb_dat_i[PW-1:0];
                                state_q <= ST_IDLE;
                            end
                        end else if (last_xfer) begin
                            // Page is staged and committed whole, so an
                            // aborted program leaves the page untouched.
                            for (int j = 0; j < 15; j++)
                                mem_q[{page_q, 4'(j)}] <= buf_q[j];
                            mem_q[{page_q, 4'hF}] <= wb_dat_i;
                            page_q  <= page_q + 1'b1;
                            irq_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            buf_q[cnt_q[3:0]] <= wb_dat_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram2e_efb_responder.sv
// Self-checking bench for ram2e_efb_responder: directed scenarios plus
// randomized command mix against a command-level UFM model.
module tb_ram2e_efb_responder;

    localparam int         PAGES = 4;
    localparam logic [7:0] IB0   = 8'hA5;
    localparam logic [7:0] IB1   = 8'h5A;
    localparam logic [7:0] CR    = 8'h70;
    localparam logic [7:0] TX    = 8'h71;
    localparam logic [7:0] RX    = 8'h73;

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] adr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ack;
    logic       irq;
    logic       en;

    int n_tests = 0;
    int n_fail  = 0;
    int irq_cnt = 0;

    logic [7:0] m_mem [PAGES][16];
    int         m_page;
    bit         m_en;

    always #5 clk = ~clk;

    ram2e_efb_responder #(
        .PAGES   (PAGES),
        .INIT_B0 (IB0),
        .INIT_B1 (IB1)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (din),
        .wb_dat_o    (dout),
        .wb_ack_o    (ack),
        .wbc_ufm_irq (irq),
        .cfg_en      (en)
    );

    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int p = 0; p < PAGES; p++)
            for (int b = 0; b < 16; b++)
                m_mem[p][b] = 8'h00;
        m_mem[0][0] = IB0;
        m_mem[0][1] = IB1;
        m_page = 0;
        m_en   = 1'b0;
    endtask

    task automatic bus(input logic w, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] q);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; din = d;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 8);
        if (!ack) check_eq("ack_timeout", {7'b0, ack}, 8'h01);
        q = dout;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] x;
        bus(1'b1, a, d, x);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        bus(1'b0, a, 8'h00, d);
    endtask

    task automatic cmd(input logic [7:0] op, input int nops);
        wr(CR, 8'h80);
        wr(TX, op);
        repeat (nops) wr(TX, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        m_reset();
    endtask

    task automatic t_enable();
        cmd(8'h74, 3); wr(CR, 8'h00);
        m_en = 1'b1;
        check_eq("cfg_en_on", {7'b0, en}, 8'h01);
    endtask

    task automatic t_disable();
        cmd(8'h26, 2); wr(CR, 8'h00);
        m_en = 1'b0;
        check_eq("cfg_en_off", {7'b0, en}, 8'h00);
    endtask

    task automatic t_setpage(input int p);
        logic [7:0] d;
        cmd(8'hB4, 3);
        repeat (3) wr(TX, 8'($urandom));
        d = (8'($urandom) & ~8'(PAGES - 1)) | 8'(p);
        wr(TX, d);
        wr(CR, 8'h00);
        if (m_en) m_page = p;
    endtask

    task automatic t_program(input int nbytes, input bit seq);
        logic [7:0] d [16];
        logic [7:0] q;
        int c0 = irq_cnt;
        cmd(8'hC9, 3);
        for (int i = 0; i < nbytes; i++) begin
            d[i] = seq ? 8'(8'h10 + i) : 8'($urandom);
            wr(TX, d[i]);
            if (i == 2) begin
                rd(RX, q);
                check_eq("din_rx_zero", q, 8'h00);
            end
        end
        wr(CR, 8'h00);
        check_eq("prog_irq", 8'(irq_cnt - c0),
                 (m_en && nbytes == 16) ? 8'h01 : 8'h00);
        if (m_en && nbytes == 16) begin
            for (int i = 0; i < 16; i++) m_mem[m_page][i] = d[i];
            m_page = (m_page + 1) % PAGES;
        end
    endtask

    task automatic t_readpage();
        logic [7:0] q;
        cmd(8'hCA, 3);
        for (int i = 0; i < 16; i++) begin
            rd(RX, q);
            check_eq($sformatf("ca_p%0d_b%0d", m_page, i), q,
                     m_en ? m_mem[m_page][i] : 8'h00);
            if (i == 3) wr(TX, 8'($urandom));
        end
        rd(RX, q);
        check_eq("ca_past_end", q, 8'h00);
        wr(CR, 8'h00);
        if (m_en) m_page = (m_page + 1) % PAGES;
    endtask

    task automatic t_status();
        logic [7:0] q;
        cmd(8'h3C, 3);
        for (int i = 0; i < 5; i++) begin
            rd(RX, q);
            check_eq($sformatf("status_b%0d", i), q,
                     (i == 3) ? {7'b0, m_en} : 8'h00);
        end
        wr(CR, 8'h00);
    endtask

    task automatic t_erase();
        cmd(8'hCB, 3); wr(CR, 8'h00);
        if (m_en)
            for (int p = 0; p < PAGES; p++)
                for (int b = 0; b < 16; b++)
                    m_mem[p][b] = 8'h00;
    endtask

    task automatic t_refresh();
        wr(CR, 8'h80);
        wr(TX, 8'hFF);
        wr(TX, 8'h74);
        wr(CR, 8'h00);
        m_en = 1'b0;
        check_eq("refresh_en", {7'b0, en}, 8'h00);
    endtask

    function automatic bit is_known(input logic [7:0] op);
        return op inside {8'h74, 8'h3C, 8'hB4, 8'hCA, 8'hC9,
                          8'hCB, 8'h26, 8'hFF};
    endfunction

    task automatic t_unknown();
        logic [7:0] op;
        do op = 8'($urandom); while (is_known(op));
        cmd(op, 3);
        wr(TX, 8'h74);
        wr(TX, 8'h74);
        wr(CR, 8'h00);
        check_eq("unknown_en", {7'b0, en}, {7'b0, m_en});
    endtask

    initial begin
        logic [7:0] q;
        int acks;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 8'h00; din = 8'h00;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {7'b0, ack}, 8'h00);
        check_eq("rst_dat", dout, 8'h00);
        check_eq("rst_irq", {7'b0, irq}, 8'h00);
        check_eq("rst_en", {7'b0, en}, 8'h00);
        @(negedge clk); rst = 1'b0;

        // Reads disabled, then enabled page 0 with INIT bytes
        t_readpage();
        t_enable();
        t_readpage();

        // Set page via 40 00 00 BE, read page 2, pointer moves to 3
        do_reset();
        t_enable();
        cmd(8'hB4, 3);
        wr(TX, 8'h40); wr(TX, 8'h00); wr(TX, 8'h00); wr(TX, 8'hBE);
        wr(CR, 8'h00);
        m_page = 2;
        t_readpage();
        t_program(16, 1'b0);
        t_setpage(3);
        t_readpage();

        // Program page 1 with 0x10..0x1F and read back
        t_setpage(1);
        t_program(16, 1'b1);
        t_setpage(1);
        t_readpage();

        // Status follows cfg_en
        t_status();
        t_disable();
        t_status();

        // Aborted program, then a strobe held three cycles
        t_enable();
        t_setpage(2);
        t_program(5, 1'b0);
        t_readpage();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        check_eq("held_stb_acks", 8'(acks), 8'h01);

        t_refresh();
        t_unknown();
        t_enable();
        t_erase();
        t_readpage();

        // Reset during page-read byte 7
        t_setpage(0);
        t_program(16, 1'b0);
        t_setpage(0);
        cmd(8'hCA, 3);
        for (int i = 0; i < 7; i++) begin
            rd(RX, q);
            check_eq("pre_rst_ca", q, m_mem[0][i]);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = RX; rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_ack", {7'b0, ack}, 8'h00);
        check_eq("midrst_en", {7'b0, en}, 8'h00);
        check_eq("midrst_dat", dout, 8'h00);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        m_reset();
        rd(RX, q);
        check_eq("post_rst_idle", q, 8'h00);
        t_enable();
        t_readpage();

        // Randomized command mix
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: t_enable();
                1: t_disable();
                2: t_setpage(int'($urandom_range(0, PAGES - 1)));
                3: t_program(16, 1'b0);
                4: t_program(int'($urandom_range(1, 15)), 1'b0);
                5: t_readpage();
                6: t_status();
                7: t_erase();
                8: t_unknown();
                default: begin
                    rd(8'h72, q);
                    check_eq("unmapped_rd", q, 8'h00);
                end
            endcase
        end
        t_enable();
        for (int p = 0; p < PAGES; p++) begin
            t_setpage(p);
            t_readpage();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
